// File: rtl/mips_pkg.sv
// Shared fetch-stage definitions: PC width, NOP encoding, fetch FSM state codes.
package mips_pkg;

  localparam int unsigned PC_W = 32;

  localparam logic [PC_W-1:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [PC_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef logic [1:0] fetch_state_t;

  localparam fetch_state_t StRun      = 2'd0;
  localparam fetch_state_t StStall    = 2'd1;
  localparam fetch_state_t StRedirect = 2'd2;

  // Sequential successor of a fetch address; wraps modulo 2^32.
  function automatic logic [PC_W-1:0] pc_plus4(input logic [PC_W-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/ifid_pipe_reg.sv
// IF/ID pipeline register: instruction, PC+4 and valid bit with hold and flush.
module ifid_pipe_reg
  import mips_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            flush_i,
  input  logic            hold_i,
  input  logic [PC_W-1:0] instr_i,
  input  logic [PC_W-1:0] pc4_i,
  output logic [PC_W-1:0] instr_o,
  output logic [PC_W-1:0] pc4_o,
  output logic            valid_o
);

  logic [PC_W-1:0] instr_q, instr_d;
  logic [PC_W-1:0] pc4_q, pc4_d;
  logic            valid_q, valid_d;

  // Flush beats hold so a squashed slot never survives a concurrent stall.
  always_comb begin
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    if (flush_i) begin
      instr_d = NOP_INSTR;
      pc4_d   = '0;
      valid_d = 1'b0;
    end else if (!hold_i) begin
      instr_d = instr_i;
      pc4_d   = pc4_i;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      instr_q <= NOP_INSTR;
      pc4_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

  assign instr_o = instr_q;
  assign pc4_o   = pc4_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/fetch_stage_ctrl.sv
// Fetch stage: PC register, next-PC selection, IF/ID register, hazard FSM,
// saturating stall/flush counters and a sticky stall watchdog.
module fetch_stage_ctrl
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned MAX_STALL = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pc_hold_i,
  input  logic             ifid_hold_i,
  input  logic             flush_i,
  input  logic             branch_i,
  input  logic             jmp_i,
  input  logic             topc_i,
  input  logic [31:0]      branch_target_i,
  input  logic [31:0]      jmp_target_i,
  input  logic [31:0]      jr_target_i,
  input  logic [31:0]      instr_i,
  output logic [31:0]      pc_o,
  output logic [31:0]      instr_ifid_o,
  output logic [31:0]      pc4_ifid_o,
  output logic             valid_ifid_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic             stall_timeout_o,
  output logic [1:0]       state_o
);

  localparam int unsigned        ConsecW   = $clog2(MAX_STALL + 1);
  localparam logic [ConsecW-1:0] ConsecMax = ConsecW'(MAX_STALL);
  localparam logic [ConsecW-1:0] ConsecOne = ConsecW'(1);
  localparam logic [CNT_W-1:0]   CntMax    = '1;
  localparam logic [CNT_W-1:0]   CntOne    = CNT_W'(1);

  logic [31:0]        pc_q, pc_d;
  fetch_state_t       state_q, state_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;
  logic [ConsecW-1:0] consec_q, consec_d;
  logic               timeout_q, timeout_d;

  logic        redirect;
  logic        stall_evt;
  logic [31:0] target;
  logic [31:0] pc_seq;

  assign redirect  = branch_i | jmp_i | topc_i;
  assign stall_evt = pc_hold_i & ~redirect;
  assign pc_seq    = pc_plus4(pc_q);

  // Later-resolving control flow wins: jr over j/jal over branch.
  always_comb begin
    if (topc_i) begin
      target = jr_target_i;
    end else if (jmp_i) begin
      target = jmp_target_i;
    end else begin
      target = branch_target_i;
    end
  end

  always_comb begin
    if (redirect) begin
      pc_d = target;
    end else if (pc_hold_i) begin
      pc_d = pc_q;
    end else begin
      pc_d = pc_seq;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StRun: begin
        if (redirect || flush_i) state_d = StRedirect;
        else if (stall_evt)      state_d = StStall;
      end
      StStall: begin
        if (redirect || flush_i) state_d = StRedirect;
        else if (pc_hold_i)      state_d = StStall;
        else                     state_d = StRun;
      end
      StRedirect: begin
        if (redirect || flush_i) state_d = StRedirect;
        else if (pc_hold_i)      state_d = StStall;
        else                     state_d = StRun;
      end
      default: state_d = StRun;
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    consec_d    = '0;
    if (stall_evt && stall_cnt_q != CntMax) begin
      stall_cnt_d = stall_cnt_q + CntOne;
    end
    if (flush_i && flush_cnt_q != CntMax) begin
      flush_cnt_d = flush_cnt_q + CntOne;
    end
    if (stall_evt) begin
      consec_d = (consec_q == ConsecMax) ? ConsecMax : consec_q + ConsecOne;
    end
    timeout_d = timeout_q | (consec_d == ConsecMax);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q        <= RESET_PC;
      state_q     <= StRun;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      consec_q    <= '0;
      timeout_q   <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      consec_q    <= consec_d;
      timeout_q   <= timeout_d;
    end
  end

  ifid_pipe_reg u_ifid (
    .clk     (clk),
    .reset   (reset),
    .flush_i (flush_i),
    .hold_i  (ifid_hold_i),
    .instr_i (instr_i),
    .pc4_i   (pc_seq),
    .instr_o (instr_ifid_o),
    .pc4_o   (pc4_ifid_o),
    .valid_o (valid_ifid_o)
  );

  assign pc_o            = pc_q;
  assign stall_cnt_o     = stall_cnt_q;
  assign flush_cnt_o     = flush_cnt_q;
  assign stall_timeout_o = timeout_q;
  assign state_o         = state_q;

endmodule

// File: tb/tb_fetch_stage_ctrl.sv
// Bench for fetch_stage_ctrl: directed vector table, hand sequences, random vs. reference model.
module tb_fetch_stage_ctrl;

  localparam logic [31:0] RPC = 32'h0000_0000;
  localparam int unsigned CW  = 4;
  localparam int unsigned MS  = 8;
  localparam int          CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          hold, ihold, flush, br, jmp, topc;
  logic [31:0]   bt, jt, rt;
  logic [31:0]   instr_i;
  logic [31:0]   pc_o, instr_ifid_o, pc4_ifid_o;
  logic          valid_ifid_o, stall_timeout_o;
  logic [CW-1:0] stall_cnt_o, flush_cnt_o;
  logic [1:0]    state_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] imem(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  assign instr_i = imem(pc_o);

  fetch_stage_ctrl #(
    .RESET_PC  (RPC),
    .CNT_W     (CW),
    .MAX_STALL (MS)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .pc_hold_i       (hold),
    .ifid_hold_i     (ihold),
    .flush_i         (flush),
    .branch_i        (br),
    .jmp_i           (jmp),
    .topc_i          (topc),
    .branch_target_i (bt),
    .jmp_target_i    (jt),
    .jr_target_i     (rt),
    .instr_i         (instr_i),
    .pc_o            (pc_o),
    .instr_ifid_o    (instr_ifid_o),
    .pc4_ifid_o      (pc4_ifid_o),
    .valid_ifid_o    (valid_ifid_o),
    .stall_cnt_o     (stall_cnt_o),
    .flush_cnt_o     (flush_cnt_o),
    .stall_timeout_o (stall_timeout_o),
    .state_o         (state_o)
  );

  // Reference model: architectural view of the fetch stage.
  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_valid, m_to;
  int          m_state, m_scnt, m_fcnt, m_consec;

  task automatic model_reset();
    m_pc = RPC; m_instr = 0; m_pc4 = 0; m_valid = 0; m_to = 0;
    m_state = 0; m_scnt = 0; m_fcnt = 0; m_consec = 0;
  endtask

  task automatic model_step();
    logic        redir;
    logic [31:0] tgt;
    if (reset) begin
      model_reset();
      return;
    end
    redir = br | jmp | topc;
    tgt   = topc ? rt : (jmp ? jt : bt);
    if (flush) begin
      m_instr = 0; m_pc4 = 0; m_valid = 0;
    end else if (!ihold) begin
      m_instr = imem(m_pc); m_pc4 = m_pc + 32'd4; m_valid = 1;
    end
    m_state = (redir || flush) ? 2 : (hold ? 1 : 0);
    if (hold && !redir) begin
      m_scnt   = (m_scnt < CMAX) ? m_scnt + 1 : CMAX;
      m_consec = (m_consec < MS) ? m_consec + 1 : MS;
    end else begin
      m_consec = 0;
    end
    if (flush) m_fcnt = (m_fcnt < CMAX) ? m_fcnt + 1 : CMAX;
    if (m_consec == MS) m_to = 1;
    m_pc = redir ? tgt : (hold ? m_pc : m_pc + 32'd4);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic h, input logic ih, input logic fl,
                        input logic b, input logic j, input logic t);
    hold = h; ihold = ih; flush = fl; br = b; jmp = j; topc = t;
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    set_in(0, 0, 0, 0, 0, 0);
    cycle();
    reset = 1'b0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pc"},    pc_o,         m_pc);
    chk({tag, ".instr"}, instr_ifid_o, m_instr);
    chk({tag, ".pc4"},   pc4_ifid_o,   m_pc4);
    chk({tag, ".valid"}, 32'(valid_ifid_o), 32'(m_valid));
    chk({tag, ".state"}, 32'(state_o),      32'(m_state));
    chk({tag, ".scnt"},  32'(stall_cnt_o),  32'(m_scnt));
    chk({tag, ".fcnt"},  32'(flush_cnt_o),  32'(m_fcnt));
    chk({tag, ".to"},    32'(stall_timeout_o), 32'(m_to));
  endtask

  typedef struct {
    logic        h, ih, fl, b, j, t;
    logic [31:0] pc, pc4;
    logic        valid;
    logic [1:0]  st;
    int          scnt, fcnt;
  } vec_t;

  vec_t tbl[12];

  initial begin
    // Targets: branch 0x40, jump 0x80, jr 0xC0.
    tbl[0]  = '{0, 0, 0, 0, 0, 0, 32'h04, 32'h04, 1, 2'd0, 0, 0};
    tbl[1]  = '{0, 0, 0, 0, 0, 0, 32'h08, 32'h08, 1, 2'd0, 0, 0};
    tbl[2]  = '{0, 0, 0, 0, 0, 0, 32'h0C, 32'h0C, 1, 2'd0, 0, 0};
    tbl[3]  = '{0, 0, 0, 0, 0, 0, 32'h10, 32'h10, 1, 2'd0, 0, 0};
    tbl[4]  = '{1, 1, 0, 0, 0, 0, 32'h10, 32'h10, 1, 2'd1, 1, 0};
    tbl[5]  = '{0, 0, 0, 0, 0, 0, 32'h14, 32'h14, 1, 2'd0, 1, 0};
    tbl[6]  = '{0, 1, 1, 1, 0, 0, 32'h40, 32'h00, 0, 2'd2, 1, 1};
    tbl[7]  = '{0, 0, 0, 0, 0, 0, 32'h44, 32'h44, 1, 2'd0, 1, 1};
    tbl[8]  = '{0, 0, 1, 1, 1, 1, 32'hC0, 32'h00, 0, 2'd2, 1, 2};
    tbl[9]  = '{0, 0, 0, 0, 1, 0, 32'h80, 32'hC4, 1, 2'd2, 1, 2};
    tbl[10] = '{1, 0, 0, 0, 0, 0, 32'h80, 32'h84, 1, 2'd1, 2, 2};
    tbl[11] = '{0, 1, 1, 0, 0, 0, 32'h84, 32'h00, 0, 2'd2, 2, 3};

    bt = 32'h40; jt = 32'h80; rt = 32'hC0;
    do_reset();
    chk("rst.pc",    pc_o, RPC);
    chk("rst.instr", instr_ifid_o, 32'h0);
    chk("rst.pc4",   pc4_ifid_o, 32'h0);
    chk("rst.valid", 32'(valid_ifid_o), 32'h0);
    chk("rst.state", 32'(state_o), 32'h0);
    chk("rst.cnt",   32'({stall_cnt_o, flush_cnt_o}), 32'h0);
    chk("rst.to",    32'(stall_timeout_o), 32'h0);

    for (int i = 0; i < 12; i++) begin
      set_in(tbl[i].h, tbl[i].ih, tbl[i].fl, tbl[i].b, tbl[i].j, tbl[i].t);
      cycle();
      chk($sformatf("vec%0d.pc", i),    pc_o, tbl[i].pc);
      chk($sformatf("vec%0d.pc4", i),   pc4_ifid_o, tbl[i].pc4);
      chk($sformatf("vec%0d.valid", i), 32'(valid_ifid_o), 32'(tbl[i].valid));
      chk($sformatf("vec%0d.instr", i), instr_ifid_o,
          tbl[i].valid ? imem(tbl[i].pc4 - 32'd4) : 32'h0);
      chk($sformatf("vec%0d.state", i), 32'(state_o), 32'(tbl[i].st));
      chk($sformatf("vec%0d.scnt", i),  32'(stall_cnt_o), 32'(tbl[i].scnt));
      chk($sformatf("vec%0d.fcnt", i),  32'(flush_cnt_o), 32'(tbl[i].fcnt));
    end

    // Watchdog: sets on the MAX_STALL-th consecutive hold, sticky afterwards.
    do_reset();
    for (int i = 1; i <= int'(MS); i++) begin
      set_in(1, 1, 0, 0, 0, 0);
      cycle();
      chk($sformatf("wd.hold%0d", i), 32'(stall_timeout_o), (i == int'(MS)) ? 32'h1 : 32'h0);
    end
    for (int i = 0; i < 3; i++) begin
      set_in(0, 0, 0, 0, 0, 0);
      cycle();
      chk("wd.sticky", 32'(stall_timeout_o), 32'h1);
    end
    chk("wd.state", 32'(state_o), 32'h0);
    // Stall counter saturates at 2^CW-1.
    for (int i = 0; i < 12; i++) begin
      set_in(1, 1, 0, 0, 0, 0);
      cycle();
    end
    chk("sat.scnt", 32'(stall_cnt_o), 32'(CMAX));
    chk("sat.state", 32'(state_o), 32'h1);
    // Reset while stalled.
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    chk("rststall.pc",    pc_o, RPC);
    chk("rststall.scnt",  32'(stall_cnt_o), 32'h0);
    chk("rststall.to",    32'(stall_timeout_o), 32'h0);
    chk("rststall.state", 32'(state_o), 32'h0);
    chk("rststall.valid", 32'(valid_ifid_o), 32'h0);

    // PC wrap from the top of the address space.
    set_in(0, 0, 0, 0, 0, 1);
    rt = 32'hFFFF_FFFC;
    cycle();
    chk("wrap.jr", pc_o, 32'hFFFF_FFFC);
    set_in(0, 0, 0, 0, 0, 0);
    cycle();
    chk("wrap.pc",    pc_o, 32'h0);
    chk("wrap.pc4",   pc4_ifid_o, 32'h0);
    chk("wrap.instr", instr_ifid_o, imem(32'hFFFF_FFFC));
    chk("wrap.valid", 32'(valid_ifid_o), 32'h1);

    // Random traffic against the reference model.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      logic h;
      h = ($urandom_range(0, 99) < 30);
      set_in(h, ($urandom_range(0, 3) != 0) ? h : ~h, ($urandom_range(0, 99) < 15),
             ($urandom_range(0, 99) < 8), ($urandom_range(0, 99) < 5),
             ($urandom_range(0, 99) < 5));
      bt = $urandom; jt = $urandom; rt = $urandom;
      reset = ($urandom_range(0, 199) == 0);
      cycle();
      reset = 1'b0;
      check_all($sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
